// File: rtl/alu_ctrl_if.sv
// Instruction handshake plus ALU command/flag bundle between the sequencer and the datapath.
// The slave modport is the controller's view; the master modport is the instruction/ALU side.
interface alu_ctrl_if;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [4:0] alu_cmd;
  logic       sc_i;
  logic       sc_o;
  logic       cnd_i;
  logic       reg_we;
  logic [1:0] rd_addr;
  logic       carry_q;
  logic       cnd_q;
  logic       branch_taken;
  logic       illegal;
  logic       done;

  modport slave (
    input  instr_valid, instr, sc_o, cnd_i,
    output instr_ready, alu_cmd, sc_i, reg_we, rd_addr,
           carry_q, cnd_q, branch_taken, illegal, done
  );

  modport master (
    output instr_valid, instr, sc_o, cnd_i,
    input  instr_ready, alu_cmd, sc_i, reg_we, rd_addr,
           carry_q, cnd_q, branch_taken, illegal, done
  );
endinterface

// File: rtl/alu_ctrl.sv
// ALU sequencing controller: decodes 9-bit instructions into ALU strobes, owns carry/condition flags,
// and expands multi-bit shifts into cnt+1 chained single-bit shift cycles.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  alu_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4,  OP_CEQ = 4'd5,  OP_LSL = 4'd6,  OP_LSR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8,  OP_CLC = 4'd9,  OP_SEC = 4'd10, OP_SHL = 4'd11;
  localparam logic [3:0] OP_SHR = 4'd12, OP_BRC = 4'd13;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       uc_q, uc_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       carry_flag_q, carry_flag_d;
  logic       cnd_flag_q, cnd_flag_d;

  logic [3:0] new_op;
  assign new_op = bus.instr[8:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      uc_q         <= 1'b0;
      rd_q         <= 2'd0;
      cnt_q        <= 3'd0;
      carry_flag_q <= 1'b0;
      cnd_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      uc_q         <= uc_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      carry_flag_q <= carry_flag_d;
      cnd_flag_q   <= cnd_flag_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    uc_d             = uc_q;
    rd_d             = rd_q;
    cnt_d            = cnt_q;
    carry_flag_d     = carry_flag_q;
    cnd_flag_d       = cnd_flag_q;
    bus.instr_ready  = 1'b0;
    bus.alu_cmd      = 5'd0;
    bus.sc_i         = 1'b0;
    bus.reg_we       = 1'b0;
    bus.rd_addr      = 2'd0;
    bus.branch_taken = 1'b0;
    bus.illegal      = 1'b0;
    bus.done         = 1'b0;

    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          op_d = new_op;
          uc_d = bus.instr[4];
          rd_d = bus.instr[1:0];
          if (new_op == OP_SHL || new_op == OP_SHR) begin
            cnt_d   = bus.instr[4:2];
            state_d = SHIFT;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        bus.rd_addr = rd_q;
        bus.sc_i    = uc_q & carry_flag_q;
        bus.done    = 1'b1;
        state_d     = IDLE;
        case (op_q)
          OP_ADD, OP_SUB, OP_LSL, OP_LSR: begin
            bus.alu_cmd  = {1'b0, op_q};
            bus.reg_we   = 1'b1;
            carry_flag_d = bus.sc_o;
          end
          OP_AND, OP_XOR, OP_MOV: begin
            bus.alu_cmd = {1'b0, op_q};
            bus.reg_we  = 1'b1;
          end
          OP_CMP, OP_CEQ: begin
            bus.alu_cmd = {1'b0, op_q};
            cnd_flag_d  = bus.cnd_i;
          end
          OP_CLC: carry_flag_d = 1'b0;
          OP_SEC: carry_flag_d = 1'b1;
          OP_BRC: bus.branch_taken = cnd_flag_q;
          default: bus.illegal = 1'b1;
        endcase
      end

      SHIFT: begin
        // Each cycle's carry-out feeds the next cycle's carry-in through the flag register.
        bus.alu_cmd  = (op_q == OP_SHL) ? 5'd6 : 5'd7;
        bus.reg_we   = 1'b1;
        bus.rd_addr  = rd_q;
        bus.sc_i     = uc_q & carry_flag_q;
        carry_flag_d = bus.sc_o;
        if (cnt_q == 3'd0) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.carry_q = carry_flag_q;
  assign bus.cnd_q   = cnd_flag_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: expected per-cycle outputs are queued when an instruction is issued
// and popped as each execute cycle is observed on the falling edge.
module tb_alu_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_if bus ();
  alu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [4:0] cmd;
    logic       sci;
    logic       we;
    logic [1:0] rd;
    logic       done;
    logic       br;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic m_carry  = 1'b0;
  logic m_cnd    = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".rdy"},   8'(bus.instr_ready), 8'd1);
    chk({tag, ".cmd"},   8'(bus.alu_cmd), 8'd0);
    chk({tag, ".we"},    8'(bus.reg_we), 8'd0);
    chk({tag, ".sci"},   8'(bus.sc_i), 8'd0);
    chk({tag, ".done"},  8'(bus.done), 8'd0);
    chk({tag, ".br"},    8'(bus.branch_taken), 8'd0);
    chk({tag, ".ill"},   8'(bus.illegal), 8'd0);
    chk({tag, ".carry"}, 8'(bus.carry_q), 8'(m_carry));
    chk({tag, ".cnd"},   8'(bus.cnd_q), 8'(m_cnd));
  endtask

  // Issue one instruction from a falling edge in IDLE; returns at the falling edge back in IDLE.
  task automatic run_op(input logic [8:0] ins, input logic [7:0] sco, input logic cnd_bit);
    logic [3:0] op;
    int         nc;
    logic       c;
    exp_t       e;
    op = ins[8:5];
    nc = (op == 4'd11 || op == 4'd12) ? int'(ins[4:2]) + 1 : 1;
    c  = m_carry;
    for (int i = 0; i < nc; i++) begin
      e     = '0;
      e.rd  = ins[1:0];
      e.sci = ins[4] & c;
      if (op == 4'd11 || op == 4'd12) begin
        e.cmd  = (op == 4'd11) ? 5'd6 : 5'd7;
        e.we   = 1'b1;
        e.done = (i == nc - 1);
        c      = sco[i];
      end else begin
        e.done = 1'b1;
        case (op)
          4'd0, 4'd1, 4'd6, 4'd7: begin e.cmd = {1'b0, op}; e.we = 1'b1; c = sco[0]; end
          4'd2, 4'd3, 4'd8:       begin e.cmd = {1'b0, op}; e.we = 1'b1; end
          4'd4, 4'd5:             e.cmd = {1'b0, op};
          4'd9:                   c = 1'b0;
          4'd10:                  c = 1'b1;
          4'd13:                  e.br = m_cnd;
          default:                e.ill = 1'b1;
        endcase
      end
      sb.push_back(e);
    end

    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    chk("accept.rdy", 8'(bus.instr_ready), 8'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 9'($urandom);
    for (int i = 0; i < nc; i++) begin
      bus.sc_o  = sco[i];
      bus.cnd_i = cnd_bit;
      e = sb.pop_front();
      chk("ex.rdy",  8'(bus.instr_ready), 8'd0);
      chk("ex.cmd",  8'(bus.alu_cmd), 8'(e.cmd));
      chk("ex.sci",  8'(bus.sc_i), 8'(e.sci));
      chk("ex.we",   8'(bus.reg_we), 8'(e.we));
      chk("ex.rd",   8'(bus.rd_addr), 8'(e.rd));
      chk("ex.done", 8'(bus.done), 8'(e.done));
      chk("ex.br",   8'(bus.branch_taken), 8'(e.br));
      chk("ex.ill",  8'(bus.illegal), 8'(e.ill));
      @(negedge clk);
    end
    m_carry = c;
    if (op == 4'd4 || op == 4'd5) m_cnd = cnd_bit;
    check_idle("post");
  endtask

  initial begin
    logic [3:0] rop;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.sc_o        = 1'b0;
    bus.cnd_i       = 1'b0;
    #12;
    check_idle("reset");
    chk("reset.rd", 8'(bus.rd_addr), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with uc=1: first sees carry 0, second sees the carry the first produced.
    run_op({4'd0, 1'b1, 2'b00, 2'd1}, 8'h01, 1'b0);
    run_op({4'd0, 1'b1, 2'b00, 2'd1}, 8'h00, 1'b0);

    // SEC then long SHR with uc=1 (cnt=7 shares bit 4 with uc), then SHR cnt=3 (uc=0).
    run_op({4'd10, 5'b0}, 8'h00, 1'b0);
    run_op({4'd12, 3'b111, 2'd2}, 8'b1011_0010, 1'b0);
    run_op({4'd10, 5'b0}, 8'h00, 1'b0);
    run_op({4'd12, 3'b011, 2'd2}, 8'b0000_0101, 1'b0);
    run_op({4'd11, 3'b100, 2'd0}, 8'b0001_1010, 1'b0);

    // CMP/BRC pairs, CEQ, and undefined opcodes.
    run_op({4'd4, 5'b0}, 8'h01, 1'b1);
    run_op({4'd13, 5'b0}, 8'h01, 1'b0);
    run_op({4'd4, 5'b0}, 8'h00, 1'b0);
    run_op({4'd13, 5'b0}, 8'h01, 1'b1);
    run_op({4'd5, 5'b1}, 8'h00, 1'b1);
    run_op({4'd10, 5'b0}, 8'h00, 1'b0);
    run_op({4'd14, 5'b0}, 8'h00, 1'b0);
    run_op({4'd15, 5'b10011}, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 13));
      if (rop > 4'd10) rop = rop + 4'd2;
      run_op({rop, 5'($urandom)}, 8'($urandom), 1'($urandom));
    end

    // Valid held high with MOV: accepted only on alternate cycles.
    bus.instr_valid = 1'b1;
    bus.instr       = {4'd8, 3'b000, 2'd3};
    for (int i = 0; i < 8; i++) begin
      chk("hold.rdy",  8'(bus.instr_ready), 8'((i % 2) == 0));
      chk("hold.we",   8'(bus.reg_we), 8'((i % 2) == 1));
      chk("hold.done", 8'(bus.done), 8'((i % 2) == 1));
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check_idle("hold_end");

    // Reset during the second SHL cycle clears flags and state at once.
    run_op({4'd4, 5'b0}, 8'h00, 1'b1);
    run_op({4'd10, 5'b0}, 8'h00, 1'b0);
    bus.instr_valid = 1'b1;
    bus.instr       = {4'd11, 3'b111, 2'd1};
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.sc_o        = 1'b0;
    chk("shl1.cmd", 8'(bus.alu_cmd), 8'd6);
    chk("shl1.rdy", 8'(bus.instr_ready), 8'd0);
    @(posedge clk);
    #2;
    chk("shl2.cmd", 8'(bus.alu_cmd), 8'd6);
    rst_n = 1'b0;
    #1;
    m_carry = 1'b0;
    m_cnd   = 1'b0;
    check_idle("midrst");
    chk("midrst.rd", 8'(bus.rd_addr), 8'd0);
    @(negedge clk);
    chk("midrst.done", 8'(bus.done), 8'd0);
    rst_n = 1'b1;
    run_op({4'd8, 3'b000, 2'd2}, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
